sm_result_display: RTL
======================

Name: sm_result_display

Overview:
- Downstream consumer of the 4-bit sign-magnitude adder/subtractor output (res[3:0], sg).
- Captures a result on a load strobe.
- Converts the captured magnitude (0..14) to two decimal digits plus a sign.
- Time-multiplexes the digits onto the board's 4-digit common-anode 7-segment display.

Parameters:
- REFRESH_CNT, 50000: clock cycles each digit stays lit; 50000 gives 1 kHz per digit at 50 MHz. The bench overrides it to 4.
- CNT_W, 16: width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_CNT.

Ports:
- clk  in  1  system clock; all state is rising-edge triggered.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  capture strobe; samples res/sg on a rising edge while high.
- res  in  4  result magnitude from the adder; legal range 0..14.
- sg  in  1  result sign; 1 means negative.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held at 1 (off).

Behaviour:
Reset (asynchronous, takes effect immediately):
- mag_r=0, sg_r=0, refresh counter=0, digit index=0.
- an=4'b1111, seg=7'h7F, dp=1.
- Reset asserted mid-scan blanks the display at once. Scanning restarts from digit 0 after release.

Capture:
- On a clk edge with load=1: mag_r<=res, sg_r<=(sg && res!=0). Negative zero therefore displays as plain 0.
- If res>14, mag_r<=14 (saturate). This value is unreachable from the adder but must be defined.
- load held high recaptures on every edge. No handshake back to the adder.

Decode (combinational from mag_r, sg_r):
- tens = (mag_r>=10), units = mag_r - 10*tens.
- Units digit: always shown, including 0.
- Tens digit: shows "1" when tens=1, otherwise blank (leading-zero suppression).
- Sign digit: shows minus (7'h3F) when sg_r=1, otherwise blank.
- Digit 3: always blank.
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Blank=7F.

Scan state machine (states = digit index):
- D0 units (an=1110), D1 tens (an=1101), D2 sign (an=1011), D3 blank (an=0111).
- Refresh counter counts 0..REFRESH_CNT-1, then wraps to 0.
- On the wrap cycle the state advances D0->D1->D2->D3->D0.
- Each state lasts exactly REFRESH_CNT cycles.

Output timing:
- an and seg are registered from the current state and captured values: one-cycle latency.
- During D3, an=0111 and seg=7F.
- The first edge after reset release drives an=1110 with the units code.

Simultaneous events:
- A capture on the same edge as a state advance is legal.
- The newly displayed digit uses the new capture starting one cycle after that edge. No output glitches beyond this one-cycle skew.
- A capture never resets the scan counter or the state.

Test Plan (REFRESH_CNT=4):
1. Assert reset, then release. The first edge gives an=1110, seg=40. After 4 cycles, an=1101, seg=7F. After 4 more, an=1011, seg=7F. After 4 more, an=0111, seg=7F.
2. load res=4'd13, sg=1. Required sequence over 16 cycles: units seg=30 (3), tens seg=79 (1), sign seg=3F (minus), blank seg=7F.
3. load res=0, sg=1 (negative zero). Sign digit shows seg=7F, units shows seg=40.
4. load res=7, sg=0. Tens digit shows 7F, units shows 78, sign shows 7F. Then load res=14 exactly on a wrap edge: the following digit shows the new value after one cycle.
5. Assert reset asynchronously mid-D2 between clock edges. an=1111 and seg=7F appear immediately. After release, scanning resumes at D0 and the captured value reads 0.
6. load res=4'd15: displays as 14 (units seg=19, tens seg=79). dp stays 1 for the whole simulation.

Source files
------------

// File: rtl/sm_result_display.sv
// sm_result_display: captures a sign-magnitude adder result and scans it as
// sign/tens/units onto a 4-digit common-anode 7-segment display.
module sm_result_display #(
  parameter int REFRESH_CNT = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] res_i,
  input  logic       sg_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  localparam logic [1:0] D0 = 2'd0;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] D2 = 2'd2;
  localparam logic [6:0] BLANK = 7'h7F;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       st_q, st_d;
  logic [3:0]       mag_q, mag_d, units;
  logic             sg_q, sg_d, wrap, tens;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = BLANK;
    endcase
  endfunction
  always_comb begin
    wrap  = cnt_q == CNT_W'(REFRESH_CNT - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    st_d  = wrap ? st_q + 2'd1 : st_q;
    // Negative zero is folded to plain zero; out-of-range input saturates at 14.
    mag_d = load_i ? (res_i > 4'd14 ? 4'd14 : res_i) : mag_q;
    sg_d  = load_i ? (sg_i && res_i != 4'd0) : sg_q;
    tens  = mag_q >= 4'd10;
    units = tens ? mag_q - 4'd10 : mag_q;
    an_d  = st_q == D0 ? 4'b1110 : st_q == D1 ? 4'b1101 : st_q == D2 ? 4'b1011 : 4'b0111;
    seg_d = st_q == D0 ? seg7(units) :
            st_q == D1 ? (tens ? 7'h79 : BLANK) :
            st_q == D2 ? (sg_q ? 7'h3F : BLANK) : BLANK;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      st_q  <= D0;
      mag_q <= '0;
      sg_q  <= 1'b0;
      an_q  <= 4'b1111;
      seg_q <= BLANK;
    end else begin
      cnt_q <= cnt_d;
      st_q  <= st_d;
      mag_q <= mag_d;
      sg_q  <= sg_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end
  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = 1'b1;
endmodule
